// File: rtl/sync_ptr_nff.sv
// Multi-channel N-stage synchroniser for Gray-coded FIFO pointers.
// Adds a binary decode, a change strobe and a sticky Gray-step violation flag.
module sync_ptr_nff #(
  parameter int unsigned ADDR_SIZE   = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CHANNELS    = 1,
  parameter bit          GRAY_CHECK  = 1'b1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [CHANNELS*(ADDR_SIZE+1)-1:0]   i_ptr,
  input  logic [CHANNELS-1:0]                 i_err_clr,
  output logic [CHANNELS*(ADDR_SIZE+1)-1:0]   o_ptr,
  output logic [CHANNELS*(ADDR_SIZE+1)-1:0]   o_ptr_bin,
  output logic [CHANNELS-1:0]                 o_chg,
  output logic [CHANNELS-1:0]                 o_err
);

  localparam int unsigned P = ADDR_SIZE + 1;
  localparam int unsigned W = CHANNELS * P;

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
    $error("sync_ptr_nff: SYNC_STAGES must be in 2..4");
  end

  if (CHANNELS < 1) begin : g_bad_channels
    $error("sync_ptr_nff: CHANNELS must be >= 1");
  end

  function automatic logic [P-1:0] gray2bin(input logic [P-1:0] g);
    logic [P-1:0] b;
    b[P-1] = g[P-1];
    for (int i = int'(P) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Synchroniser chain; only the last two stages feed anything downstream.
  (* ASYNC_REG = "TRUE" *) logic [W-1:0] sync_q [SYNC_STAGES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < int'(SYNC_STAGES); k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= i_ptr;
      for (int k = 1; k < int'(SYNC_STAGES); k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  logic [W-1:0] pre_ptr;
  assign pre_ptr = sync_q[SYNC_STAGES-2];
  assign o_ptr   = sync_q[SYNC_STAGES-1];

  for (genvar c = 0; c < int'(CHANNELS); c++) begin : g_ch
    logic [P-1:0] g_pre;
    logic [P-1:0] g_out;
    logic [P-1:0] bin_q;
    logic         chg_q;
    logic         err_q;

    assign g_pre = pre_ptr[c*P +: P];
    assign g_out = o_ptr[c*P +: P];

    // Decode/compare the stage ahead of o_ptr so results line up with it.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        bin_q <= '0;
        chg_q <= 1'b0;
      end else begin
        bin_q <= gray2bin(g_pre);
        chg_q <= (g_pre != g_out);
      end
    end

    if (GRAY_CHECK) begin : g_check
      logic viol;
      assign viol = ($countones(g_pre ^ g_out) > 1);

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          err_q <= 1'b0;
        end else if (viol) begin
          err_q <= 1'b1;
        end else if (i_err_clr[c]) begin
          err_q <= 1'b0;
        end
      end
    end else begin : g_nocheck
      assign err_q = 1'b0;
    end

    assign o_ptr_bin[c*P +: P] = bin_q;
    assign o_chg[c]            = chg_q;
    assign o_err[c]            = err_q;
  end

endmodule

// File: tb/tb_sync_ptr_nff.sv
// Self-checking bench for sync_ptr_nff: directed tables, corner sequences and random
// traffic compared against a sample-history reference model.
module tb_sync_ptr_nff;

  localparam int unsigned AS = 4;
  localparam int unsigned NS = 3;
  localparam int unsigned CH = 2;
  localparam int unsigned P  = AS + 1;
  localparam int unsigned W  = CH * P;

  logic          clk;
  logic          rst;
  logic [W-1:0]  i_ptr;
  logic [CH-1:0] i_err_clr;
  logic [W-1:0]  o_ptr;
  logic [W-1:0]  o_ptr_bin;
  logic [CH-1:0] o_chg;
  logic [CH-1:0] o_err;

  int checks = 0;
  int errors = 0;

  sync_ptr_nff #(
    .ADDR_SIZE  (AS),
    .SYNC_STAGES(NS),
    .CHANNELS   (CH),
    .GRAY_CHECK (1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_ptr    (i_ptr),
    .i_err_clr(i_err_clr),
    .o_ptr    (o_ptr),
    .o_ptr_bin(o_ptr_bin),
    .o_chg    (o_chg),
    .o_err    (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [P-1:0] bin2gray(input logic [P-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the parity of all Gray bits at or above it.
  function automatic logic [P-1:0] ref_g2b(input logic [P-1:0] g);
    logic [P-1:0] b = '0;
    for (int i = 0; i < int'(P); i++) b ^= (g >> i);
    return b;
  endfunction

  // Reference model: o_ptr is the value sampled NS-1 edges before the current one.
  logic [W-1:0]  m_q [$];
  logic [W-1:0]  m_ptr;
  logic [CH-1:0] m_chg;
  logic [CH-1:0] m_err;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q = {};
      for (int i = 0; i < int'(NS); i++) m_q.push_back('0);
      m_ptr <= '0;
      m_chg <= '0;
      m_err <= '0;
    end else begin : upd
      logic [W-1:0]  nxt;
      logic [CH-1:0] e;
      logic [CH-1:0] ch;
      m_q.push_front(i_ptr);
      nxt = m_q[NS-1];
      void'(m_q.pop_back());
      e = m_err;
      for (int c = 0; c < int'(CH); c++) begin
        ch[c] = (nxt[c*P +: P] != m_ptr[c*P +: P]);
        if ($countones(nxt[c*P +: P] ^ m_ptr[c*P +: P]) > 1) e[c] = 1'b1;
        else if (i_err_clr[c]) e[c] = 1'b0;
      end
      m_ptr <= nxt;
      m_chg <= ch;
      m_err <= e;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".ptr"}, 64'(o_ptr), 64'(m_ptr));
    for (int c = 0; c < int'(CH); c++) begin
      check({tag, ".bin"}, 64'(o_ptr_bin[c*P +: P]), 64'(ref_g2b(m_ptr[c*P +: P])));
    end
    check({tag, ".chg"}, 64'(o_chg), 64'(m_chg));
    check({tag, ".err"}, 64'(o_err), 64'(m_err));
  endtask

  task automatic step(input string tag);
    @(negedge clk);
    check_all(tag);
  endtask

  typedef struct {
    logic [P-1:0] gray;
    logic [P-1:0] bin;
  } vec_t;

  vec_t vecs [9];
  int   nchg;
  logic [P-1:0] cur [CH];

  initial begin
    vecs[0] = '{5'b00001, 5'd1};
    vecs[1] = '{5'b00011, 5'd2};
    vecs[2] = '{5'b00010, 5'd3};
    vecs[3] = '{5'b00110, 5'd4};
    vecs[4] = '{5'b01010, 5'd12};
    vecs[5] = '{5'b10110, 5'd27};
    vecs[6] = '{5'b11000, 5'd16};
    vecs[7] = '{5'b10000, 5'd31};
    vecs[8] = '{5'b00000, 5'd0};

    // Reset held with a nonzero input
    rst       = 1'b0;
    i_ptr     = {CH{5'b10110}};
    i_err_clr = '0;
    repeat (3) @(negedge clk);
    check("rst.ptr", 64'(o_ptr), 64'd0);
    check("rst.bin", 64'(o_ptr_bin), 64'd0);
    check("rst.chg", 64'(o_chg), 64'd0);
    check("rst.err", 64'(o_err), 64'd0);

    // Release with zero input, then latency of a single step on ch0
    i_ptr = '0;
    rst   = 1'b1;
    repeat (4) step("idle");
    i_ptr[4:0] = 5'b00001;
    step("lat1");
    check("lat.e1", 64'(o_ptr[4:0]), 64'd0);
    step("lat2");
    check("lat.e2", 64'(o_ptr[4:0]), 64'd0);
    step("lat3");
    check("lat.e3.ptr", 64'(o_ptr[4:0]), 64'b00001);
    check("lat.e3.bin", 64'(o_ptr_bin[4:0]), 64'b00001);
    check("lat.e3.chg", 64'(o_chg), 64'b01);
    step("lat4");
    check("lat.e4.chg", 64'(o_chg), 64'b00);

    // Table of Gray values with hand-computed binary decodes
    for (int v = 0; v < 9; v++) begin
      i_ptr[4:0] = vecs[v].gray;
      repeat (NS + 1) step("tbl");
      check("tbl.ptr", 64'(o_ptr[4:0]), 64'(vecs[v].gray));
      check("tbl.bin", 64'(o_ptr_bin[4:0]), 64'(vecs[v].bin));
    end

    // Clear any flags, then count through the full Gray sequence and wrap
    i_err_clr = '1;
    repeat (5) step("clr");
    i_err_clr = '0;
    check("clr.err", 64'(o_err), 64'd0);
    for (int i = 1; i <= 32; i++) begin
      i_ptr[4:0] = bin2gray(5'(i % 32));
      nchg = 0;
      for (int k = 0; k < 4; k++) begin
        step("cnt");
        if (o_chg[0]) nchg++;
      end
      check("cnt.chg_once", 64'(nchg), 64'd1);
      check("cnt.bin", 64'(o_ptr_bin[4:0]), 64'(i % 32));
      check("cnt.err", 64'(o_err), 64'd0);
    end

    // Two-bit jump sets the sticky flag; a clear pulse drops it
    i_ptr[4:0] = 5'b00011;
    step("v1");
    step("v2");
    check("viol.early", 64'(o_err[0]), 64'd0);
    step("v3");
    check("viol.set", 64'(o_err[0]), 64'd1);
    step("v4");
    step("v5");
    check("viol.sticky", 64'(o_err[0]), 64'd1);
    i_err_clr = 2'b01;
    step("vclr");
    check("viol.clr", 64'(o_err[0]), 64'd0);
    i_ptr[4:0] = 5'b00010;
    repeat (4) step("vback");
    i_ptr[4:0] = 5'b00000;
    repeat (4) step("vback");
    check("viol.legal_back", 64'(o_err[0]), 64'd0);
    // Violation while clear is held: violation wins
    i_ptr[4:0] = 5'b00011;
    repeat (3) step("vwin");
    check("viol.wins", 64'(o_err[0]), 64'd1);
    i_err_clr = '0;
    step("vwin");
    check("viol.wins_hold", 64'(o_err[0]), 64'd1);

    // Channel independence
    i_err_clr = 2'b11;
    step("mclr");
    i_err_clr = '0;
    check("mc.clr", 64'(o_err), 64'd0);
    i_ptr[4:0] = 5'b00111;
    repeat (3) step("mc0");
    check("mc.chg", 64'(o_chg), 64'b01);
    check("mc.ch1_ptr", 64'(o_ptr[9:5]), 64'd0);
    step("mc0");
    i_ptr[9:5] = 5'b00101;
    repeat (3) step("mc1");
    check("mc.err", 64'(o_err), 64'b10);
    step("mc1");

    // Mid-operation reset with a value in the first stage
    i_ptr[4:0] = 5'b00110;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("mrst.ptr", 64'(o_ptr), 64'd0);
    check("mrst.bin", 64'(o_ptr_bin), 64'd0);
    check("mrst.chg", 64'(o_chg), 64'd0);
    check("mrst.err", 64'(o_err), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    step("mrel1");
    check("mrel.e1", 64'(o_ptr[4:0]), 64'd0);
    step("mrel2");
    step("mrel3");
    check("mrel.ptr", 64'(o_ptr[4:0]), 64'b00110);
    step("mrel4");

    // Random traffic: mostly legal increments, occasional jumps and clears
    cur[0] = ref_g2b(i_ptr[4:0]);
    cur[1] = ref_g2b(i_ptr[9:5]);
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < int'(CH); c++) begin
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 6) cur[c] = cur[c] + 5'd1;
        else if (r == 6) cur[c] = 5'($urandom);
        i_ptr[c*P +: P] = bin2gray(cur[c]);
        i_err_clr[c]    = ($urandom_range(0, 7) == 0);
      end
      step("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
